// File: rtl/gpio_multi_pkg.sv
// Shared register map and address-decode helpers for the gpio_multi controller.
// Each port occupies one 32-byte window; registers sit on 4-byte boundaries.
package gpio_multi_pkg;

    localparam int unsigned BUS_WIDTH   = 32;
    localparam int unsigned PORT_STRIDE = 32'h20;
    localparam int unsigned PORT_SHIFT  = $clog2(PORT_STRIDE);
    localparam int unsigned MAX_PORTS   = 4;

    localparam logic [4:0] REG_DATA = 5'h00;
    localparam logic [4:0] REG_DIR  = 5'h04;
    localparam logic [4:0] REG_SET  = 5'h08;
    localparam logic [4:0] REG_CLR  = 5'h0C;
    localparam logic [4:0] REG_IE   = 5'h10;
    localparam logic [4:0] REG_RISE = 5'h14;
    localparam logic [4:0] REG_FALL = 5'h18;
    localparam logic [4:0] REG_IS   = 5'h1C;

    // All eight word-aligned offsets in the window are populated, so only
    // misaligned offsets are undefined.
    function automatic logic offset_defined(input logic [4:0] offset);
        return offset[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/gpio_port.sv
// One GPIO port: output/direction registers, input synchroniser, edge detect,
// write-1-to-clear interrupt status and the port-local read mux.
module gpio_port
    import gpio_multi_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk_bus,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [4:0]       offset,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    input  logic [WIDTH-1:0] pins,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] oe,
    output logic             irq_pending
);

    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] ie_q, ie_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic [WIDTH-1:0] is_q, is_d;
    logic [WIDTH-1:0] is_clr;

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  prev_q;
    logic [WIDTH-1:0]                  sync;
    logic [WIDTH-1:0]                  rise_evt;
    logic [WIDTH-1:0]                  fall_evt;

    assign sync     = sync_q[SYNC_STAGES-1];
    assign rise_evt = sync & ~prev_q & rise_q;
    assign fall_evt = ~sync & prev_q & fall_q;

    always_comb begin
        out_d  = out_q;
        dir_d  = dir_q;
        ie_d   = ie_q;
        rise_d = rise_q;
        fall_d = fall_q;
        is_clr = '0;
        if (wr_en) begin
            case (offset)
                REG_DATA: out_d  = wdata;
                REG_DIR:  dir_d  = wdata;
                REG_SET:  out_d  = out_q | wdata;
                REG_CLR:  out_d  = out_q & ~wdata;
                REG_IE:   ie_d   = wdata;
                REG_RISE: rise_d = wdata;
                REG_FALL: fall_d = wdata;
                REG_IS:   is_clr = wdata;
                default:  ;
            endcase
        end
        // New edges are ORed in after the clear so a colliding event survives.
        is_d = (is_q & ~is_clr) | rise_evt | fall_evt;
    end

    always_ff @(posedge clk_bus or posedge rst) begin
        if (rst) begin
            out_q  <= '0;
            dir_q  <= '0;
            ie_q   <= '0;
            rise_q <= '0;
            fall_q <= '0;
            is_q   <= '0;
        end else begin
            out_q  <= out_d;
            dir_q  <= dir_d;
            ie_q   <= ie_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            is_q   <= is_d;
        end
    end

    always_ff @(posedge clk_bus or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pins};
            prev_q <= sync;
        end
    end

    always_comb begin
        rdata = '0;
        case (offset)
            REG_DATA: rdata = sync;
            REG_DIR:  rdata = dir_q;
            REG_SET:  rdata = out_q;
            REG_CLR:  rdata = out_q;
            REG_IE:   rdata = ie_q;
            REG_RISE: rdata = rise_q;
            REG_FALL: rdata = fall_q;
            REG_IS:   rdata = is_q;
            default:  rdata = '0;
        endcase
    end

    assign out         = out_q;
    assign oe          = dir_q;
    assign irq_pending = |(is_q & ie_q);

endmodule

// File: rtl/gpio_multi.sv
// Multi-port GPIO controller on the 8-bit-address peripheral bus: splits the
// address into port and offset, muxes read data and registers the shared irq.
module gpio_multi
    import gpio_multi_pkg::*;
#(
    parameter int unsigned N_PORTS     = 2,
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                       clk_bus,
    input  logic                       rst,
    input  logic [7:0]                 bus_address,
    input  logic [31:0]                bus_data_i,
    output logic [31:0]                bus_data_o,
    input  logic                       bus_read,
    input  logic                       bus_write,
    input  logic [N_PORTS*WIDTH-1:0]   gpio_i,
    output logic [N_PORTS*WIDTH-1:0]   gpio_o,
    output logic [N_PORTS*WIDTH-1:0]   gpio_oe,
    output logic                       irq
);

    logic [1:0]         port_sel;
    logic [4:0]         offset;
    logic               addr_hit;
    logic [WIDTH-1:0]   wdata;
    logic [N_PORTS-1:0] port_wr;
    logic [N_PORTS-1:0] irq_pending;
    logic [WIDTH-1:0]   port_rdata [N_PORTS];
    logic               irq_q;

    assign offset   = bus_address[PORT_SHIFT-1:0];
    assign port_sel = bus_address[PORT_SHIFT +: 2];
    assign wdata    = bus_data_i[WIDTH-1:0];

    // Upper half of the address space and absent ports decode to nothing.
    assign addr_hit = ~bus_address[7] && (32'(port_sel) < N_PORTS) && offset_defined(offset);

    always_comb begin
        port_wr = '0;
        for (int unsigned i = 0; i < N_PORTS; i++) begin
            port_wr[i] = bus_write && addr_hit && (port_sel == 2'(i));
        end
    end

    for (genvar p = 0; p < N_PORTS; p++) begin : g_port
        gpio_port #(
            .WIDTH       (WIDTH),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_port (
            .clk_bus     (clk_bus),
            .rst         (rst),
            .wr_en       (port_wr[p]),
            .offset      (offset),
            .wdata       (wdata),
            .rdata       (port_rdata[p]),
            .pins        (gpio_i[p*WIDTH +: WIDTH]),
            .out         (gpio_o[p*WIDTH +: WIDTH]),
            .oe          (gpio_oe[p*WIDTH +: WIDTH]),
            .irq_pending (irq_pending[p])
        );
    end

    always_comb begin
        bus_data_o = '0;
        if (bus_read && addr_hit) begin
            for (int unsigned i = 0; i < N_PORTS; i++) begin
                if (port_sel == 2'(i)) begin
                    bus_data_o = BUS_WIDTH'(port_rdata[i]);
                end
            end
        end
    end

    always_ff @(posedge clk_bus or posedge rst) begin
        if (rst) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= |irq_pending;
        end
    end

    assign irq = irq_q;

endmodule

// File: tb/tb_gpio_multi.sv
// Directed self-checking bench for gpio_multi (2x32 build plus a 2x8 build).
module tb_gpio_multi;

    localparam int unsigned NP = 2;
    localparam int unsigned W  = 32;
    localparam int unsigned SS = 2;

    logic                clk_bus = 1'b0;
    logic                rst     = 1'b1;
    logic [7:0]          bus_address;
    logic [31:0]         bus_data_i;
    logic [31:0]         bus_data_o;
    logic                bus_read;
    logic                bus_write;
    logic [NP*W-1:0]     gpio_i;
    logic [NP*W-1:0]     gpio_o;
    logic [NP*W-1:0]     gpio_oe;
    logic                irq;

    logic [7:0]          b8_address;
    logic [31:0]         b8_data_i;
    logic [31:0]         b8_data_o;
    logic                b8_read;
    logic                b8_write;
    logic [NP*8-1:0]     b8_gpio_i;
    logic [NP*8-1:0]     b8_gpio_o;
    logic [NP*8-1:0]     b8_gpio_oe;
    logic                b8_irq;

    int unsigned tests = 0;
    int unsigned fails = 0;
    logic [31:0] rd_val;

    always #5 clk_bus = ~clk_bus;

    gpio_multi #(
        .N_PORTS     (NP),
        .WIDTH       (W),
        .SYNC_STAGES (SS)
    ) dut (
        .clk_bus     (clk_bus),
        .rst         (rst),
        .bus_address (bus_address),
        .bus_data_i  (bus_data_i),
        .bus_data_o  (bus_data_o),
        .bus_read    (bus_read),
        .bus_write   (bus_write),
        .gpio_i      (gpio_i),
        .gpio_o      (gpio_o),
        .gpio_oe     (gpio_oe),
        .irq         (irq)
    );

    gpio_multi #(
        .N_PORTS     (NP),
        .WIDTH       (8),
        .SYNC_STAGES (SS)
    ) dut8 (
        .clk_bus     (clk_bus),
        .rst         (rst),
        .bus_address (b8_address),
        .bus_data_i  (b8_data_i),
        .bus_data_o  (b8_data_o),
        .bus_read    (b8_read),
        .bus_write   (b8_write),
        .gpio_i      (b8_gpio_i),
        .gpio_o      (b8_gpio_o),
        .gpio_oe     (b8_gpio_oe),
        .irq         (b8_irq)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_bus);
        #1;
    endtask

    task automatic wr(input logic [7:0] addr, input logic [31:0] data);
        bus_address = addr;
        bus_data_i  = data;
        bus_write   = 1'b1;
        tick();
        bus_write   = 1'b0;
    endtask

    task automatic rd(input logic [7:0] addr, output logic [31:0] data);
        bus_address = addr;
        bus_read    = 1'b1;
        #1;
        data        = bus_data_o;
        bus_read    = 1'b0;
    endtask

    initial begin
        bus_address = '0;
        bus_data_i  = '0;
        bus_read    = 1'b0;
        bus_write   = 1'b0;
        gpio_i      = '0;
        b8_address  = '0;
        b8_data_i   = '0;
        b8_read     = 1'b0;
        b8_write    = 1'b0;
        b8_gpio_i   = '0;

        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Reset state
        check("reset_gpio_o", gpio_o, 64'h0);
        check("reset_gpio_oe", gpio_oe, 64'h0);
        check("reset_irq", {63'h0, irq}, 64'h0);
        check("idle_bus_data_o", bus_data_o, 64'h0);
        rd(8'h04, rd_val);
        check("reset_dir0", rd_val, 64'h0);

        // Output, set, clear
        wr(8'h04, 32'hFFFF_FFFF);
        wr(8'h00, 32'h0000_00F0);
        check("dir0_oe", gpio_oe[31:0], 64'hFFFF_FFFF);
        check("data0_out", gpio_o[31:0], 64'hF0);
        wr(8'h08, 32'h1);
        check("set0_out", gpio_o[31:0], 64'hF1);
        wr(8'h0C, 32'h30);
        check("clr0_out", gpio_o[31:0], 64'hC1);
        rd(8'h08, rd_val);
        check("set0_read", rd_val, 64'hC1);
        rd(8'h0C, rd_val);
        check("clr0_read", rd_val, 64'hC1);
        check("port1_out_untouched", gpio_o[63:32], 64'h0);
        check("port1_oe_untouched", gpio_oe[63:32], 64'h0);

        // Read during write returns the pre-write value
        bus_address = 8'h24;
        bus_data_i  = 32'hFF;
        bus_write   = 1'b1;
        bus_read    = 1'b1;
        #1;
        check("rdw_old_value", bus_data_o, 64'h0);
        tick();
        bus_write   = 1'b0;
        bus_read    = 1'b0;
        check("dir1_oe", gpio_oe[63:32], 64'hFF);
        rd(8'h24, rd_val);
        check("dir1_read", rd_val, 64'hFF);

        // Input synchroniser latency; output bits read the pad, not OUT
        gpio_i[63:32] = 32'hA5A5_0000;
        tick();
        rd(8'h20, rd_val);
        check("data1_sync_early", rd_val, 64'h0);
        tick();
        rd(8'h20, rd_val);
        check("data1_sync_done", rd_val, 64'hA5A5_0000);
        rd(8'h00, rd_val);
        check("data0_no_loopback", rd_val, 64'h0);

        // Rising-edge interrupt on port 1 bit 0
        wr(8'h34, 32'h1);
        wr(8'h30, 32'h1);
        rd(8'h3C, rd_val);
        check("is1_before_edge", rd_val, 64'h0);
        gpio_i[32] = 1'b1;
        repeat (3) tick();
        rd(8'h3C, rd_val);
        check("is1_after_edge", rd_val, 64'h1);
        check("irq_not_yet", {63'h0, irq}, 64'h0);
        tick();
        check("irq_raised", {63'h0, irq}, 64'h1);
        wr(8'h3C, 32'h1);
        rd(8'h3C, rd_val);
        check("is1_cleared", rd_val, 64'h0);
        check("irq_still_high", {63'h0, irq}, 64'h1);
        tick();
        check("irq_dropped", {63'h0, irq}, 64'h0);

        // W1C colliding with a falling edge on port 0 bit 2
        wr(8'h18, 32'h4);
        gpio_i[2] = 1'b1;
        repeat (4) tick();
        rd(8'h1C, rd_val);
        check("is0_no_rise_event", rd_val, 64'h0);
        gpio_i[2] = 1'b0;
        repeat (2) tick();
        wr(8'h1C, 32'h4);
        rd(8'h1C, rd_val);
        check("is0_set_wins", rd_val, 64'h4);
        check("irq_ie0_off", {63'h0, irq}, 64'h0);
        wr(8'h1C, 32'h4);
        rd(8'h1C, rd_val);
        check("is0_w1c_alone", rd_val, 64'h0);

        // Decode holes: absent port, upper half, misaligned offset
        wr(8'h40, 32'hFFFF_FFFF);
        wr(8'h88, 32'hFFFF_0000);
        wr(8'h01, 32'h0);
        check("decode_out_unchanged", gpio_o, {32'h0, 32'hC1});
        check("decode_oe_unchanged", gpio_oe, {32'hFF, 32'hFFFF_FFFF});
        rd(8'h40, rd_val);
        check("read_absent_port", rd_val, 64'h0);
        rd(8'h88, rd_val);
        check("read_upper_0x88", rd_val, 64'h0);
        rd(8'h84, rd_val);
        check("read_upper_0x84", rd_val, 64'h0);
        rd(8'h05, rd_val);
        check("read_misaligned", rd_val, 64'h0);

        // Narrow build masks unused upper bits
        b8_address = 8'h00;
        b8_data_i  = 32'hFFFF_FFFF;
        b8_write   = 1'b1;
        tick();
        b8_write   = 1'b0;
        b8_address = 8'h08;
        b8_read    = 1'b1;
        #1;
        check("w8_set0_read", b8_data_o, 64'hFF);
        b8_read    = 1'b0;
        check("w8_gpio_o", b8_gpio_o, 64'h00FF);

        // Asynchronous reset mid-cycle with irq pending
        gpio_i[32] = 1'b0;
        repeat (4) tick();
        gpio_i[32] = 1'b1;
        repeat (4) tick();
        check("irq_before_reset", {63'h0, irq}, 64'h1);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_gpio_o", gpio_o, 64'h0);
        check("async_rst_gpio_oe", gpio_oe, 64'h0);
        check("async_rst_irq", {63'h0, irq}, 64'h0);
        check("async_rst_w8_gpio_o", b8_gpio_o, 64'h0);
        for (int p = 0; p < 2; p++) begin
            for (int r = 0; r < 8; r++) begin
                rd(8'(p * 32 + r * 4), rd_val);
                check($sformatf("rst_read_p%0d_off%0h", p, r * 4), rd_val, 64'h0);
            end
        end
        rst = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
